// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out word deserializer with valid/ready output
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic [CW-1:0]    cap_idx;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] word;
    logic             complete;

    always_comb begin
        // A sof bit always starts a fresh word from zero at index 0.
        cap_idx = sof ? '0 : cnt_q;
        pos     = (LSB_FIRST != 0) ? cap_idx : (CW'(WIDTH - 1) - cap_idx);
        word    = sof ? '0 : shreg_q;
        word[pos] = sin;

        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        frame_err_d  = 1'b0;
        complete     = 1'b0;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        if (sin_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (sof) begin
                        shreg_d = word;
                        cnt_d   = CW'(1);
                        state_d = S_SHIFT;
                    end
                end
                default: begin
                    if (sof) begin
                        frame_err_d = 1'b1;
                        shreg_d     = word;
                        cnt_d       = CW'(1);
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
                        complete = 1'b1;
                        shreg_d  = word;
                        cnt_d    = '0;
                        state_d  = S_IDLE;
                    end else begin
                        shreg_d = word;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            endcase
        end

        // Load only if the holding register is empty or draining this cycle.
        if (complete) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = word;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == S_SHIFT);
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed bench for sipo_deserializer
module tb_sipo_deserializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sof = 1'b0;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, busy, overrun, frame_err;

    logic       m_ready = 1'b1;
    logic [7:0] m_dout;
    logic       m_dout_valid, m_busy, m_overrun, m_frame_err;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    logic [7:0] xfer[$];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1)) u_dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .overrun(overrun), .frame_err(frame_err)
    );

    sipo_deserializer #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .dout(m_dout), .dout_valid(m_dout_valid), .dout_ready(m_ready),
        .busy(m_busy), .overrun(m_overrun), .frame_err(m_frame_err)
    );

    // Observe transfers and frame_err pulses between edges.
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) xfer.push_back(dout);
        if (frame_err) ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic b, input logic s);
        sin = b; sof = s; sin_valid = 1'b1;
        @(posedge clk); #1;
        sin_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] w);
        for (int i = 0; i < 8; i++) bit_in(w[i], i == 0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        xfer.delete();
        ferr_cnt = 0;
    endtask

    initial begin
        logic [7:0] w;
        #1;
        chk("reset_dout", dout, 8'h00);
        chk("reset_valid", dout_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        do_reset();

        // Continuous 0xA5 frame, held output
        w = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            bit_in(w[i], i == 0);
            if (i == 6) begin
                chk("a5_valid_before_last", dout_valid, 1'b0);
                chk("a5_busy_mid", busy, 1'b1);
            end
        end
        chk("a5_valid", dout_valid, 1'b1);
        chk("a5_dout", dout, 8'hA5);
        chk("a5_busy_done", busy, 1'b0);
        chk("a5_msb_dout", m_dout, 8'hA5);
        idle(2);
        chk("a5_hold", dout, 8'hA5);
        dout_ready = 1'b1; idle(1); dout_ready = 1'b0;
        chk("a5_drained", dout_valid, 1'b0);

        // Same frame with gaps after bits 2 and 5
        for (int i = 0; i < 8; i++) begin
            bit_in(w[i], i == 0);
            if (i == 1 || i == 4) begin
                idle(3);
                chk("gap_busy", busy, 1'b1);
            end
        end
        chk("gap_dout", dout, 8'hA5);
        chk("gap_valid", dout_valid, 1'b1);
        chk("gap_overrun", overrun, 1'b0);
        chk("gap_ferr", ferr_cnt, 0);
        dout_ready = 1'b1; idle(1); dout_ready = 1'b0;

        // Overrun: two frames, no consumer
        do_reset();
        frame(8'h3C);
        chk("ovr_first", dout, 8'h3C);
        chk("ovr_first_flag", overrun, 1'b0);
        frame(8'hC3);
        chk("ovr_dout_kept", dout, 8'h3C);
        chk("ovr_flag", overrun, 1'b1);
        dout_ready = 1'b1; idle(1); dout_ready = 1'b0;
        chk("ovr_valid_after", dout_valid, 1'b0);
        chk("ovr_xfer_cnt", xfer.size(), 1);
        if (xfer.size() >= 1) chk("ovr_xfer0", xfer[0], 8'h3C);
        idle(2);
        chk("ovr_sticky", overrun, 1'b1);

        // Back-to-back frames with a ready consumer
        do_reset();
        dout_ready = 1'b1;
        frame(8'h01);
        chk("b2b_first_valid", dout_valid, 1'b1);
        frame(8'h80);
        frame(8'hFF);
        idle(2);
        chk("b2b_cnt", xfer.size(), 3);
        if (xfer.size() == 3) begin
            chk("b2b_0", xfer[0], 8'h01);
            chk("b2b_1", xfer[1], 8'h80);
            chk("b2b_2", xfer[2], 8'hFF);
        end
        chk("b2b_overrun", overrun, 1'b0);

        // sof on the 5th bit restarts the frame
        do_reset();
        for (int i = 0; i < 4; i++) bit_in(1'b1, i == 0);
        w = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            bit_in(w[i], i == 0);
            if (i == 0) begin
                chk("ferr_pulse", frame_err, 1'b1);
                chk("ferr_busy", busy, 1'b1);
            end
            if (i == 1) chk("ferr_one_cycle", frame_err, 1'b0);
        end
        idle(2);
        chk("ferr_cnt", ferr_cnt, 1);
        chk("ferr_xfer_cnt", xfer.size(), 1);
        if (xfer.size() >= 1) chk("ferr_xfer0", xfer[0], 8'h5A);

        // Asynchronous reset mid-frame, then a clean 0x96 frame
        xfer.delete();
        for (int i = 0; i < 4; i++) bit_in(1'b0, i == 0);
        chk("rst_busy_before", busy, 1'b1);
        chk("rst_dout_before", dout, 8'h5A);
        rst = 1'b1; #1;
        chk("rst_async_dout", dout, 8'h00);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_valid", dout_valid, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        frame(8'h96);
        chk("rst_96_dout", dout, 8'h96);
        chk("rst_96_valid", dout_valid, 1'b1);
        idle(2);
        chk("rst_96_xfer_cnt", xfer.size(), 1);

        // MSB-first placement
        do_reset();
        frame(8'h01);
        chk("msb_valid", m_dout_valid, 1'b1);
        chk("msb_dout", m_dout, 8'h80);
        chk("lsb_same_stream", dout, 8'h01);
        dout_ready = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
